mips_controller: RTL
====================

# mips_controller

Multicycle control unit for the 8-bit MIPS datapath. It decodes the fetched opcode and funct fields and steps through a Moore state machine. Each cycle it drives the datapath enables and multiplexer selects, and it drives the 7-bit ALU control word that the ALU consumes. It sits between the instruction register and the datapath, and it is the only producer of `alucontrol`.

## Interface
Parameters:
- none; datapath width is fixed at 8 bits, with 4 fetch bytes per instruction.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  asynchronous, active-low reset
- op  in  6  instruction[31:26]
- funct  in  6  instruction[5:0]
- zero  in  1  ALU zero flag
- memwrite  out  1  memory write enable
- iord  out  1  memory address select: 0 = PC, 1 = ALUOut
- memtoreg  out  1  register write data select: 0 = ALUOut, 1 = MDR
- regdst  out  1  destination register select: 0 = rt, 1 = rd
- regwrite  out  1  register file write enable
- alusrca  out  1  ALU A select: 0 = PC, 1 = register A
- alusrcb  out  2  ALU B select: 00 = register B, 01 = constant 1, 10 = immediate, 11 = branch offset
- pcsource  out  2  next-PC select: 00 = ALU result, 01 = ALUOut, 10 = jump target
- pcen  out  1  PC enable, equal to pcwrite | (branch & zero)
- irwrite  out  4  one-hot byte enable for the instruction register
- alucontrol  out  7  ALU control word (see below)

## Operation
- `alucontrol` fields:
  - [6:3] is a logic truth table indexed by {a,b}: 00 selects bit 6, 01 bit 5, 10 bit 4, 11 bit 3.
  - [2] is the adder carry-in.
  - [1:0] is the result select: 00 = sum, 01 = logic, 10 = slt, 11 = shift.
  - The shifter also reads [6:5]: 00 = sll, 01 = srl, 10 = sra.
- `alucontrol` words: ADD=0101000, SUB=1010100, SLT=1010110, AND=0001001, OR=0111001, XOR=0110001, SLL=0000011, SRL=0100011, SRA=1000011.
- Opcodes: RTYPE=000000, LB=100000, SB=101000, BEQ=000100, J=000010, ADDI=001000.
- Functs: add 100000, sub 100010, and 100100, or 100101, xor 100110, slt 101010, sll 000000, srl 000010, sra 000011.
- States and the outputs each one asserts (unlisted outputs are 0; `alucontrol` is ADD unless stated):
  - FETCH1 to FETCH4: irwrite=0001, 0010, 0100, 1000 in turn; alusrcb=01; pcwrite=1. Each advances to the next state; FETCH4 goes to DECODE.
  - DECODE: alusrcb=11. Next state by op: LB/SB to MEMADR, RTYPE to RTYPEEX, BEQ to BEQEX, J to JEX, ADDI to ADDIEX, any other op to FETCH1.
  - MEMADR: alusrca=1, alusrcb=10. Goes to LBRD for LB, SBWR for SB.
  - LBRD: iord=1. Goes to LBWR.
  - LBWR: regwrite=1, memtoreg=1. Goes to FETCH1.
  - SBWR: iord=1, memwrite=1. Goes to FETCH1.
  - RTYPEEX: alusrca=1, alusrcb=00, `alucontrol` decoded from funct. Goes to RTYPEWR.
  - RTYPEWR: regdst=1, regwrite=1; `alucontrol` still decoded from funct. Goes to FETCH1.
  - BEQEX: alusrca=1, alusrcb=00, SUB, branch=1, pcsource=01. Goes to FETCH1.
  - JEX: pcwrite=1, pcsource=10. Goes to FETCH1.
  - ADDIEX: alusrca=1, alusrcb=10. Goes to ADDIWR.
  - ADDIWR: regwrite=1. Goes to FETCH1.
- An unknown funct in RTYPEEX or RTYPEWR decodes to ADD with regwrite forced to 0, so the instruction acts as a NOP.

## Timing
- The state register updates on the rising edge of clk and resets asynchronously to FETCH1.
- While reset=0: pcen, irwrite, regwrite and memwrite are forced to 0. All other outputs take their FETCH1 values: alusrcb=01, `alucontrol`=ADD, and the rest 0.
- The first fetch happens on the first rising edge after reset is released.
- All outputs are combinational from state, op, funct and zero; there is no extra register stage.
- pcen during BEQEX follows `zero` within the same cycle.
- Cycles per instruction: RTYPE 7, LB 8, SB 7, ADDI 7, BEQ 6, J 6, unknown op 5.
- Asserting reset mid-instruction aborts it immediately, with no partial register or memory write after the asserting edge.

## Configuration
- `MIPS_SHIFT_EN` defined: the sll, srl and sra functs decode to SLL, SRL and SRA, and RTYPEWR writes the result.
- `MIPS_SHIFT_EN` undefined: those functs are treated as unknown functs, giving ADD with regwrite=0.

## Structure
- Package `mips_pkg` holds:
  - the `statetype_t` enum;
  - the opcode and funct localparams;
  - the `alucontrol` word localparams.
- Sub-module `aludec` is a combinational funct-to-`alucontrol` decoder that also outputs a funct-valid flag. It contains the `MIPS_SHIFT_EN` guard.

## Test plan
- Reset low mid-FETCH3, then release: state is FETCH1; enables are 0 while reset is low; irwrite=0001 and pcen=1 on the first cycle after release.
- op=000000, funct=100010: RTYPEEX drives `alucontrol`=1010100; regwrite=1 and regdst=1 in cycle 7; next cycle is FETCH1.
- op=100000: MEMADR, then LBRD with iord=1, then LBWR with memtoreg=1 and regwrite=1; 8 cycles total.
- op=000100 with zero=1, then again with zero=0: in BEQEX pcen=1 and pcsource=01, then pcen=0 on the second instruction; 6 cycles each.
- op=000000, funct=000011: with `MIPS_SHIFT_EN`, `alucontrol`=1000011 and regwrite=1; without it, ADD and regwrite=0.
- op=111111: DECODE goes directly to FETCH1; 5 cycles; no write enable is asserted after fetch.

Source files
------------

// File: rtl/mips_pkg.sv
// Shared definitions for the multicycle MIPS control unit: state encoding,
// opcode/funct field values and the ALU control words.
package mips_pkg;

  typedef enum logic [3:0] {
    FETCH1, FETCH2, FETCH3, FETCH4, DECODE,
    MEMADR, LBRD, LBWR, SBWR,
    RTYPEEX, RTYPEWR, BEQEX, JEX, ADDIEX, ADDIWR
  } statetype_t;

  // instruction[31:26]
  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_LB    = 6'b100000;
  localparam logic [5:0] OP_SB    = 6'b101000;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_ADDI  = 6'b001000;

  // instruction[5:0] for R-type
  localparam logic [5:0] FN_ADD = 6'b100000;
  localparam logic [5:0] FN_SUB = 6'b100010;
  localparam logic [5:0] FN_AND = 6'b100100;
  localparam logic [5:0] FN_OR  = 6'b100101;
  localparam logic [5:0] FN_XOR = 6'b100110;
  localparam logic [5:0] FN_SLT = 6'b101010;
  localparam logic [5:0] FN_SLL = 6'b000000;
  localparam logic [5:0] FN_SRL = 6'b000010;
  localparam logic [5:0] FN_SRA = 6'b000011;

  // {truth table[6:3], carry-in[2], result select[1:0]}
  localparam logic [6:0] ALU_ADD = 7'b0101000;
  localparam logic [6:0] ALU_SUB = 7'b1010100;
  localparam logic [6:0] ALU_SLT = 7'b1010110;
  localparam logic [6:0] ALU_AND = 7'b0001001;
  localparam logic [6:0] ALU_OR  = 7'b0111001;
  localparam logic [6:0] ALU_XOR = 7'b0110001;
  localparam logic [6:0] ALU_SLL = 7'b0000011;
  localparam logic [6:0] ALU_SRL = 7'b0100011;
  localparam logic [6:0] ALU_SRA = 7'b1000011;

endpackage

// File: rtl/mips_controller_if.sv
// Instruction-field inputs and datapath control outputs of the controller.
// master: the controller; slave: the datapath / instruction register side.
interface mips_controller_if;
  logic [5:0] op;
  logic [5:0] funct;
  logic       zero;
  logic       memwrite;
  logic       iord;
  logic       memtoreg;
  logic       regdst;
  logic       regwrite;
  logic       alusrca;
  logic [1:0] alusrcb;
  logic [1:0] pcsource;
  logic       pcen;
  logic [3:0] irwrite;
  logic [6:0] alucontrol;

  modport master (
    input  op, funct, zero,
    output memwrite, iord, memtoreg, regdst, regwrite, alusrca,
           alusrcb, pcsource, pcen, irwrite, alucontrol
  );

  modport slave (
    output op, funct, zero,
    input  memwrite, iord, memtoreg, regdst, regwrite, alusrca,
           alusrcb, pcsource, pcen, irwrite, alucontrol
  );
endinterface

// File: rtl/mips_controller_aludec.sv
// Combinational funct -> ALU control decoder. Unknown functs give ADD with
// funct_valid low so the controller can suppress the register write.
// Optional feature macro: MIPS_SHIFT_EN (decode sll/srl/sra).
module aludec
  import mips_pkg::*;
(
  input  logic [5:0] funct,
  output logic [6:0] alucontrol,
  output logic       funct_valid
);

  // Map each supported funct to its ALU word
  always_comb begin
    alucontrol  = ALU_ADD;
    funct_valid = 1'b1;
    case (funct)
      FN_ADD: alucontrol = ALU_ADD;
      FN_SUB: alucontrol = ALU_SUB;
      FN_AND: alucontrol = ALU_AND;
      FN_OR:  alucontrol = ALU_OR;
      FN_XOR: alucontrol = ALU_XOR;
      FN_SLT: alucontrol = ALU_SLT;
`ifdef MIPS_SHIFT_EN
      FN_SLL: alucontrol = ALU_SLL;
      FN_SRL: alucontrol = ALU_SRL;
      FN_SRA: alucontrol = ALU_SRA;
`endif
      default: begin
        alucontrol  = ALU_ADD;
        funct_valid = 1'b0;
      end
    endcase
  end

endmodule

// File: rtl/mips_controller.sv
// Multicycle Moore control unit for the 8-bit MIPS datapath: four byte
// fetches, decode, then per-opcode execute/writeback states.
// Optional feature macro: MIPS_SHIFT_EN (handled inside aludec).
module mips_controller
  import mips_pkg::*;
(
  input  logic              clk,
  input  logic              reset,   // asynchronous, active low
  mips_controller_if.master bus
);

  statetype_t state;
  logic [6:0] funct_alu;
  logic       funct_valid;

  logic       memwrite, iord, memtoreg, regdst, regwrite, alusrca;
  logic [1:0] alusrcb, pcsource;
  logic [3:0] irwrite;
  logic [6:0] alucontrol;
  logic       pcwrite, branch;

  aludec u_aludec (
    .funct      (bus.funct),
    .alucontrol (funct_alu),
    .funct_valid(funct_valid)
  );

  // State register with opcode-driven sequencing
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= FETCH1;
    end else begin
      case (state)
        FETCH1:  state <= FETCH2;
        FETCH2:  state <= FETCH3;
        FETCH3:  state <= FETCH4;
        FETCH4:  state <= DECODE;
        DECODE: begin
          case (bus.op)
            OP_LB, OP_SB: state <= MEMADR;
            OP_RTYPE:     state <= RTYPEEX;
            OP_BEQ:       state <= BEQEX;
            OP_J:         state <= JEX;
            OP_ADDI:      state <= ADDIEX;
            default:      state <= FETCH1;
          endcase
        end
        MEMADR: begin
          if (bus.op == OP_LB)      state <= LBRD;
          else if (bus.op == OP_SB) state <= SBWR;
          else                      state <= FETCH1;
        end
        LBRD:    state <= LBWR;
        RTYPEEX: state <= RTYPEWR;
        ADDIEX:  state <= ADDIWR;
        default: state <= FETCH1;   // LBWR, SBWR, RTYPEWR, BEQEX, JEX, ADDIWR
      endcase
    end
  end

  // Moore outputs per state; enables masked while reset is held low
  always_comb begin
    memwrite   = 1'b0;
    iord       = 1'b0;
    memtoreg   = 1'b0;
    regdst     = 1'b0;
    regwrite   = 1'b0;
    alusrca    = 1'b0;
    alusrcb    = 2'b00;
    pcsource   = 2'b00;
    irwrite    = 4'b0000;
    alucontrol = ALU_ADD;
    pcwrite    = 1'b0;
    branch     = 1'b0;
    case (state)
      FETCH1:  begin irwrite = 4'b0001; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH2:  begin irwrite = 4'b0010; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH3:  begin irwrite = 4'b0100; alusrcb = 2'b01; pcwrite = 1'b1; end
      FETCH4:  begin irwrite = 4'b1000; alusrcb = 2'b01; pcwrite = 1'b1; end
      DECODE:  alusrcb = 2'b11;
      MEMADR:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      LBRD:    iord = 1'b1;
      LBWR:    begin regwrite = 1'b1; memtoreg = 1'b1; end
      SBWR:    begin iord = 1'b1; memwrite = 1'b1; end
      RTYPEEX: begin alusrca = 1'b1; alucontrol = funct_alu; end
      RTYPEWR: begin
        regdst     = 1'b1;
        regwrite   = funct_valid;   // unknown funct retires as a NOP
        alucontrol = funct_alu;
      end
      BEQEX:   begin
        alusrca    = 1'b1;
        alucontrol = ALU_SUB;
        branch     = 1'b1;
        pcsource   = 2'b01;
      end
      JEX:     begin pcwrite = 1'b1; pcsource = 2'b10; end
      ADDIEX:  begin alusrca = 1'b1; alusrcb = 2'b10; end
      ADDIWR:  regwrite = 1'b1;
      default: ;
    endcase
    // state is already FETCH1 under reset; only the enables need killing
    if (!reset) begin
      irwrite  = 4'b0000;
      pcwrite  = 1'b0;
      branch   = 1'b0;
      regwrite = 1'b0;
      memwrite = 1'b0;
    end
  end

  assign bus.memwrite   = memwrite;
  assign bus.iord       = iord;
  assign bus.memtoreg   = memtoreg;
  assign bus.regdst     = regdst;
  assign bus.regwrite   = regwrite;
  assign bus.alusrca    = alusrca;
  assign bus.alusrcb    = alusrcb;
  assign bus.pcsource   = pcsource;
  assign bus.irwrite    = irwrite;
  assign bus.alucontrol = alucontrol;
  assign bus.pcen       = pcwrite | (branch & bus.zero);

endmodule
